axi_wr_out: RTL and testbench
=============================

AXI_WR_OUT -- requirements
Module: axi_wr_out

Interface
REQ-001 SHALL have parameter BAND_WIDTH, default 512: data beat width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 64: AXI address width.
REQ-003 SHALL have parameter BURST_LEN, default 16: beats per AXI burst, range 1..256.
REQ-004 SHALL have parameter TOTAL_BEATS, default 40000: beats per frame (800 rows x 50 beats), an integer multiple of BURST_LEN.
REQ-005 SHALL have port clk, input, 1: the only clock.
REQ-006 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-007 SHALL have port i_start, input, 1: single-cycle frame start pulse.
REQ-008 SHALL have port i_base_addr, input, ADDR_WIDTH: frame base byte address, sampled on i_start.
REQ-009 SHALL have port i_im_data, input, BAND_WIDTH: stream data from the output buffer.
REQ-010 SHALL have port i_im_vld, input, 1: stream data valid.
REQ-011 SHALL have port o_im_out_txfer, output, 1: beat consumed this cycle.
REQ-012 SHALL have port i_im_out_last, input, 1: upstream end-of-frame marker, qualified by o_im_out_txfer.
REQ-013 SHALL have AXI4 write-master ports m_axi_awaddr/awlen[7:0]/awsize[2:0]/awburst[1:0]/awvalid (out), awready (in); wdata[BAND_WIDTH]/wstrb[BAND_WIDTH/8]/wlast/wvalid (out), wready (in); bresp[1:0]/bvalid (in), bready (out).
REQ-014 SHALL have port o_done, output, 1: one-cycle frame-complete pulse.
REQ-015 SHALL have port o_err, output, 1: sticky error flag.

Function
REQ-016 SHALL implement FSM states IDLE, ADDR, DATA, RESP, DONE.
REQ-017 IDLE: on i_start, latch i_base_addr into the address register, clear the burst counter and o_err, and go to ADDR; i_start outside IDLE SHALL be ignored.
REQ-018 ADDR: hold awvalid=1 with awaddr = the current address register; on awvalid&awready, go to DATA.
REQ-019 awlen SHALL equal BURST_LEN-1, awsize SHALL equal log2(BAND_WIDTH/8) (6 at default), awburst SHALL equal 2'b01, and wstrb SHALL be all ones, all constant.
REQ-020 DATA: wvalid SHALL equal i_im_vld combinationally, wdata SHALL equal i_im_data, and o_im_out_txfer SHALL equal wvalid&wready; there SHALL be no internal buffering and zero-cycle latency.
REQ-021 A beat counter (log2(BURST_LEN) bits) SHALL increment on each o_im_out_txfer.
REQ-022 wlast SHALL be asserted when the beat counter equals BURST_LEN-1.
REQ-023 The transfer with wlast SHALL return the beat counter to 0 and move to RESP.
REQ-024 Outside DATA, wvalid and o_im_out_txfer SHALL be 0, so upstream is stalled.
REQ-025 RESP: bready SHALL be 1 only in RESP.
REQ-026 On bvalid in RESP, the block SHALL add BURST_LEN*BAND_WIDTH/8 (1024 at default) to the address register, with wrap-around modulo 2^ADDR_WIDTH, and increment the burst counter.
REQ-027 On leaving RESP, the block SHALL go to DONE if the burst counter reaches TOTAL_BEATS/BURST_LEN, else to ADDR.
REQ-028 DONE: o_done SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-029 The block SHALL hold exactly one burst outstanding; it SHALL not issue AW for burst n+1 before the B response for burst n.
REQ-030 bresp != 2'b00 SHALL set o_err, which SHALL stay set until the next accepted i_start or reset; the frame SHALL continue.
REQ-031 If i_im_out_last is asserted on a transfer that is not the final frame beat, o_err SHALL be set.
REQ-032 If the final frame beat transfers without i_im_out_last, o_err SHALL be set.
REQ-033 AXI rules: awvalid/wvalid SHALL not drop before the handshake, except that wvalid follows i_im_vld, whose source holds data until txfer.

Reset
REQ-034 While rst_n=0, the block SHALL go to IDLE, and awvalid, wvalid, wlast, bready, o_im_out_txfer, o_done and o_err SHALL be 0; awaddr and all counters SHALL be 0.
REQ-035 Reset mid-burst SHALL abandon the frame with no recovery; the AXI slave is reset in the same domain.

Verification
REQ-036 i_start with base 0x1000_0000, always-ready slave, TOTAL_BEATS=32 -> 2 bursts at awaddr 0x1000_0000 and 0x1000_0400, awlen=15, wlast on beats 16/32, o_done 1 cycle after the second bvalid, o_err=0.
REQ-037 Random wready and i_im_vld gaps -> wdata sequence matches input order, no beat lost or duplicated, o_im_out_txfer count = 32.
REQ-038 awready delayed 10 cycles -> awvalid/awaddr held stable, o_im_out_txfer=0 throughout.
REQ-039 bresp=2'b10 on burst 1 -> o_err=1 held, frame still completes with o_done; next i_start clears o_err.
REQ-040 i_im_out_last on beat 20 of 32 -> o_err=1.
REQ-041 rst_n low during DATA beat 5 then release -> all outputs 0, FSM IDLE; a new i_start runs a clean frame from the new base.

Source files
------------

// File: rtl/axi_wr_out.sv
// axi_wr_out: streams a frame of beats to memory as AXI4 INCR write bursts, one burst outstanding.
// Ports: clk/rst_n (async active-low); i_start/i_base_addr start a frame at a byte address;
// i_im_data/i_im_vld/i_im_out_last are the upstream stream, o_im_out_txfer acknowledges a beat;
// m_axi_aw*/w*/b* form the AXI4 write master; o_done pulses at frame end; o_err is a sticky error.
module axi_wr_out #(
  parameter int BAND_WIDTH  = 512,
  parameter int ADDR_WIDTH  = 64,
  parameter int BURST_LEN   = 16,
  parameter int TOTAL_BEATS = 40000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_start,
  input  logic [ADDR_WIDTH-1:0]   i_base_addr,
  input  logic [BAND_WIDTH-1:0]   i_im_data,
  input  logic                    i_im_vld,
  output logic                    o_im_out_txfer,
  input  logic                    i_im_out_last,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [BAND_WIDTH-1:0]   m_axi_wdata,
  output logic [BAND_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic                    o_done,
  output logic                    o_err
);
  localparam int NBURST = TOTAL_BEATS / BURST_LEN;
  localparam int BCW = BURST_LEN > 1 ? $clog2(BURST_LEN) : 1;
  localparam int NCW = $clog2(NBURST + 1);
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(BURST_LEN * BAND_WIDTH / 8);
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(BURST_LEN - 1);
  localparam logic [NCW-1:0] LAST_BURST = NCW'(NBURST - 1);
  typedef enum logic [2:0] {IDLE, ADDR, DATA, RESP, DONE} state_t;
  state_t state, state_nx;
  logic [ADDR_WIDTH-1:0] addr;
  logic [BCW-1:0] beat;
  logic [NCW-1:0] bursts;
  logic err;
  logic final_beat;
  assign m_axi_awaddr   = addr;
  assign m_axi_awlen    = 8'(BURST_LEN - 1);
  assign m_axi_awsize   = 3'($clog2(BAND_WIDTH / 8));
  assign m_axi_awburst  = 2'b01;
  assign m_axi_awvalid  = state == ADDR;
  assign m_axi_wdata    = i_im_data;
  assign m_axi_wstrb    = '1;
  assign m_axi_wvalid   = state == DATA && i_im_vld;
  assign m_axi_wlast    = state == DATA && beat == LAST_BEAT;
  assign o_im_out_txfer = m_axi_wvalid && m_axi_wready;
  assign m_axi_bready   = state == RESP;
  assign o_done         = state == DONE;
  assign o_err          = err;
  // last beat of the last burst is the frame's final beat; upstream's last marker must coincide with it
  assign final_beat = bursts == LAST_BURST && m_axi_wlast;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = i_start ? ADDR : IDLE;
      ADDR: state_nx = m_axi_awready ? DATA : ADDR;
      DATA: state_nx = o_im_out_txfer && m_axi_wlast ? RESP : DATA;
      RESP: state_nx = !m_axi_bvalid ? RESP : bursts == LAST_BURST ? DONE : ADDR;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      addr   <= '0;
      beat   <= '0;
      bursts <= '0;
      err    <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && i_start) begin
        addr   <= i_base_addr;
        beat   <= '0;
        bursts <= '0;
        err    <= 1'b0;
      end
      if (o_im_out_txfer) beat <= m_axi_wlast ? '0 : beat + 1'b1;
      if (m_axi_bready && m_axi_bvalid) begin
        addr   <= addr + STEP;
        bursts <= bursts + 1'b1;
        if (m_axi_bresp != 2'b00) err <= 1'b1;
      end
      if (o_im_out_txfer && i_im_out_last != final_beat) err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_axi_wr_out.sv
// tb_axi_wr_out: randomized frame-level checks of axi_wr_out against a queue-based reference model.
module tb_axi_wr_out;
  localparam int BW = 512, AW = 64, BL = 16, TB = 32, NB = TB / BL;
  localparam int STEP = BL * BW / 8;
  logic clk = 1'b0, rst_n = 1'b0, i_start = 1'b0;
  logic [AW-1:0] i_base_addr = '0;
  logic [BW-1:0] i_im_data = '0;
  logic i_im_vld = 1'b0, i_im_out_last = 1'b0;
  logic o_im_out_txfer, o_done, o_err;
  logic [AW-1:0] m_axi_awaddr;
  logic [7:0] m_axi_awlen;
  logic [2:0] m_axi_awsize;
  logic [1:0] m_axi_awburst;
  logic m_axi_awvalid, m_axi_awready = 1'b0;
  logic [BW-1:0] m_axi_wdata;
  logic [BW/8-1:0] m_axi_wstrb;
  logic m_axi_wlast, m_axi_wvalid, m_axi_wready = 1'b0;
  logic [1:0] m_axi_bresp = 2'b00;
  logic m_axi_bvalid = 1'b0, m_axi_bready;
  axi_wr_out #(.BAND_WIDTH(BW), .ADDR_WIDTH(AW), .BURST_LEN(BL), .TOTAL_BEATS(TB)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_base_addr(i_base_addr),
    .i_im_data(i_im_data), .i_im_vld(i_im_vld), .o_im_out_txfer(o_im_out_txfer),
    .i_im_out_last(i_im_out_last), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .o_done(o_done), .o_err(o_err)
  );
  always #5 clk = ~clk;
  int n_vec = 0, n_err = 0;
  logic [AW-1:0] aw_q[$];
  logic [BW-1:0] wd_q[$], src[$];
  bit wl_q[$];
  int txfers, done_cyc, lastb_cyc, done_hi, aw_unstable, txfer_in_addr, aw_wait;
  bit timeout, err_after_start;
  logic [7:0] s_len;
  logic [2:0] s_size;
  logic [1:0] s_burst;
  logic [BW/8-1:0] s_strb;
  task automatic run_frame(input logic [AW-1:0] base, input int aw_delay, input int wr_pct,
                           input int vld_pct, input int err_burst, input int last_idx,
                           input int abort_beat);
    int sent = 0, awv_cyc = 0, b_cnt = 0;
    bit took = 0, b_took = 0, pend_b = 0, prev_awv = 0, got_done = 0;
    logic [AW-1:0] prev_addr = '0;
    logic [BW-1:0] d;
    aw_q.delete(); wd_q.delete(); wl_q.delete(); src.delete();
    txfers = 0; done_cyc = -1; lastb_cyc = -2; done_hi = 0; aw_unstable = 0; txfer_in_addr = 0;
    aw_wait = -1; timeout = 0;
    for (int i = 0; i < TB; i++) begin
      for (int k = 0; k < BW / 32; k++) d[k*32 +: 32] = $urandom;
      src.push_back(d);
    end
    @(negedge clk);
    i_base_addr = base;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    i_base_addr = ~base;
    for (int cyc = 0; cyc < 3000 && !got_done; cyc++) begin
      if (took) begin sent++; i_im_vld = 1'b0; end
      if (b_took) begin b_cnt++; m_axi_bvalid = 1'b0; pend_b = 0; end
      m_axi_awready = awv_cyc >= aw_delay;
      m_axi_wready = $urandom_range(99) < wr_pct;
      if (!i_im_vld && sent < TB) i_im_vld = $urandom_range(99) < vld_pct;
      i_im_data = sent < TB ? src[sent] : '0;
      i_im_out_last = i_im_vld && sent == last_idx;
      if (pend_b && !m_axi_bvalid) m_axi_bvalid = 1'($urandom_range(1));
      m_axi_bresp = b_cnt == err_burst ? 2'b10 : 2'b00;
      #1;
      if (cyc == 0) err_after_start = o_err;
      if (prev_awv && (!m_axi_awvalid || m_axi_awaddr != prev_addr)) aw_unstable++;
      if (m_axi_awvalid && o_im_out_txfer) txfer_in_addr++;
      prev_awv = m_axi_awvalid && !m_axi_awready;
      prev_addr = m_axi_awaddr;
      if (m_axi_awvalid) begin
        if (m_axi_awready) begin
          aw_q.push_back(m_axi_awaddr);
          s_len = m_axi_awlen; s_size = m_axi_awsize; s_burst = m_axi_awburst; s_strb = m_axi_wstrb;
          aw_wait = awv_cyc;
          awv_cyc = 0;
        end else awv_cyc++;
      end
      took = o_im_out_txfer;
      if (took) begin
        wd_q.push_back(m_axi_wdata);
        wl_q.push_back(m_axi_wlast);
        txfers++;
        if (m_axi_wlast) pend_b = 1;
      end
      b_took = m_axi_bready && m_axi_bvalid;
      if (b_took) lastb_cyc = cyc;
      if (o_done) begin done_hi++; done_cyc = cyc; got_done = 1; end
      if (abort_beat >= 0 && txfers == abort_beat) break;
      @(negedge clk);
    end
    if (abort_beat >= 0) return;
    timeout = !got_done;
    i_im_vld = 1'b0; i_im_out_last = 1'b0; m_axi_bvalid = 1'b0;
    #1;
    if (o_done) done_hi++;
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready, o_im_out_txfer, o_done, o_err} !== 7'b0) begin
      n_err++; $display("FAIL reset_outputs: got %b want 0000000", {m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready, o_im_out_txfer, o_done, o_err});
    end
    n_vec++;
    if (m_axi_awaddr !== '0) begin n_err++; $display("FAIL reset_awaddr: got %h want 0", m_axi_awaddr); end
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    n_vec++;
    if (m_axi_awvalid !== 1'b0) begin n_err++; $display("FAIL idle_awvalid: got %b want 0", m_axi_awvalid); end
  endtask
  task automatic test_basic;
    logic [AW-1:0] base = 64'h1000_0000;
    run_frame(base, 0, 100, 100, -1, TB - 1, -1);
    n_vec++;
    if (timeout) begin n_err++; $display("FAIL basic_timeout: got no o_done want o_done"); end
    n_vec++;
    if (aw_q.size() != NB) begin n_err++; $display("FAIL basic_aw_count: got %0d want %0d", aw_q.size(), NB); end
    for (int k = 0; k < NB && k < aw_q.size(); k++) begin
      n_vec++;
      if (aw_q[k] !== base + AW'(k * STEP)) begin n_err++; $display("FAIL basic_awaddr%0d: got %h want %h", k, aw_q[k], base + AW'(k * STEP)); end
    end
    n_vec++;
    if ({s_len, s_size, s_burst} !== {8'd15, 3'd6, 2'b01}) begin n_err++; $display("FAIL basic_aw_const: got %h/%h/%h want 0f/6/1", s_len, s_size, s_burst); end
    n_vec++;
    if (s_strb !== {(BW/8){1'b1}}) begin n_err++; $display("FAIL basic_wstrb: got %h want all ones", s_strb); end
    for (int i = 0; i < wl_q.size(); i++) begin
      n_vec++;
      if (wl_q[i] !== ((i + 1) % BL == 0)) begin n_err++; $display("FAIL basic_wlast%0d: got %b want %b", i, wl_q[i], (i + 1) % BL == 0); end
    end
    n_vec++;
    if (txfers != TB) begin n_err++; $display("FAIL basic_txfers: got %0d want %0d", txfers, TB); end
    n_vec++;
    if (done_cyc != lastb_cyc + 1) begin n_err++; $display("FAIL basic_done_time: got %0d want %0d", done_cyc, lastb_cyc + 1); end
    n_vec++;
    if (done_hi != 1) begin n_err++; $display("FAIL basic_done_width: got %0d want 1", done_hi); end
    n_vec++;
    if (o_err !== 1'b0) begin n_err++; $display("FAIL basic_err: got %b want 0", o_err); end
  endtask
  task automatic test_random;
    logic [AW-1:0] base;
    for (int r = 0; r < 3; r++) begin
      base = {$urandom, $urandom} & ~64'h3f;
      if (r == 2) base = 64'hffff_ffff_ffff_fc00;
      run_frame(base, $urandom_range(3), 50 + 10 * r, 40 + 20 * r, -1, TB - 1, -1);
      n_vec++;
      if (timeout || txfers != TB || wd_q.size() != TB) begin
        n_err++; $display("FAIL rand%0d_count: got %0d beats timeout=%0d want %0d", r, txfers, timeout, TB);
      end
      for (int i = 0; i < TB && i < wd_q.size(); i++) begin
        n_vec++;
        if (wd_q[i] !== src[i]) begin n_err++; $display("FAIL rand%0d_wdata%0d: got %h want %h", r, i, wd_q[i][31:0], src[i][31:0]); end
      end
      for (int k = 0; k < NB && k < aw_q.size(); k++) begin
        n_vec++;
        if (aw_q[k] !== base + AW'(k * STEP)) begin n_err++; $display("FAIL rand%0d_awaddr%0d: got %h want %h", r, k, aw_q[k], base + AW'(k * STEP)); end
      end
      n_vec++;
      if (o_err !== 1'b0 || aw_unstable != 0) begin n_err++; $display("FAIL rand%0d_err: got err=%b unstable=%0d want 0/0", r, o_err, aw_unstable); end
    end
  endtask
  task automatic test_aw_delay;
    run_frame(64'h2000_0000, 10, 100, 100, -1, TB - 1, -1);
    n_vec++;
    if (aw_unstable != 0) begin n_err++; $display("FAIL awdly_stable: got %0d drops want 0", aw_unstable); end
    n_vec++;
    if (txfer_in_addr != 0) begin n_err++; $display("FAIL awdly_txfer: got %0d beats in ADDR want 0", txfer_in_addr); end
    n_vec++;
    if (aw_wait != 10) begin n_err++; $display("FAIL awdly_wait: got %0d want 10", aw_wait); end
    n_vec++;
    if (timeout || txfers != TB) begin n_err++; $display("FAIL awdly_frame: got %0d beats want %0d", txfers, TB); end
  endtask
  task automatic test_bresp_err;
    run_frame(64'h3000_0000, 0, 80, 80, 0, TB - 1, -1);
    n_vec++;
    if (timeout || done_hi != 1) begin n_err++; $display("FAIL berr_done: got %0d done cycles want 1", done_hi); end
    n_vec++;
    if (o_err !== 1'b1) begin n_err++; $display("FAIL berr_err: got %b want 1", o_err); end
    run_frame(64'h3100_0000, 0, 100, 100, -1, TB - 1, -1);
    n_vec++;
    if (err_after_start !== 1'b0) begin n_err++; $display("FAIL berr_clear: got %b want 0", err_after_start); end
    n_vec++;
    if (o_err !== 1'b0) begin n_err++; $display("FAIL berr_clean: got %b want 0", o_err); end
  endtask
  task automatic test_last_err;
    run_frame(64'h4000_0000, 0, 100, 100, -1, 19, -1);
    n_vec++;
    if (timeout || o_err !== 1'b1) begin n_err++; $display("FAIL early_last: got %b want 1", o_err); end
    run_frame(64'h4100_0000, 0, 100, 100, -1, TB, -1);
    n_vec++;
    if (timeout || o_err !== 1'b1) begin n_err++; $display("FAIL missing_last: got %b want 1", o_err); end
  endtask
  task automatic test_reset_mid;
    logic [AW-1:0] base = 64'h5000_0000;
    run_frame(64'h4800_0000, 0, 100, 100, -1, TB - 1, 5);
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready, o_im_out_txfer, o_done, o_err} !== 7'b0 || m_axi_awaddr !== '0) begin
      n_err++; $display("FAIL midrst_outputs: got %b addr %h want 0", {m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready, o_im_out_txfer, o_done, o_err}, m_axi_awaddr);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_axi_bvalid = 1'b0;
    @(negedge clk);
    #1;
    n_vec++;
    if (m_axi_awvalid !== 1'b0 || o_im_out_txfer !== 1'b0 || m_axi_wvalid !== 1'b0) begin
      n_err++; $display("FAIL midrst_idle: got aw=%b w=%b tx=%b want 0", m_axi_awvalid, m_axi_wvalid, o_im_out_txfer);
    end
    i_im_vld = 1'b0;
    run_frame(base, 1, 70, 70, -1, TB - 1, -1);
    n_vec++;
    if (timeout || txfers != TB || aw_q.size() != NB) begin n_err++; $display("FAIL midrst_frame: got %0d beats %0d bursts want %0d/%0d", txfers, aw_q.size(), TB, NB); end
    n_vec++;
    if (aw_q.size() > 0 && aw_q[0] !== base) begin n_err++; $display("FAIL midrst_base: got %h want %h", aw_q[0], base); end
    n_vec++;
    if (wd_q.size() > 0 && wd_q[0] !== src[0]) begin n_err++; $display("FAIL midrst_data: got %h want %h", wd_q[0][31:0], src[0][31:0]); end
    n_vec++;
    if (o_err !== 1'b0) begin n_err++; $display("FAIL midrst_err: got %b want 0", o_err); end
  endtask
  initial begin
    test_reset;
    test_basic;
    test_random;
    test_aw_delay;
    test_bresp_err;
    test_last_err;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
